// File: rtl/sd_block_read.sv
// SPI-mode SD single-block read engine: CMD17, R1, start token, payload byte stream, CRC, 8 tail clocks.
// Optional payload CRC16-CCITT check is built only when SD_CRC16_CHK_EN is defined.
module sd_block_read #(
   parameter int unsigned BLOCK_BYTES   = 512,
   parameter int unsigned RESP_TIMEOUT  = 128,
   parameter int unsigned TOKEN_TIMEOUT = 4096,
   parameter int unsigned ADDR_SHIFT    = 9
) (
   input  logic        SD_CLK,
   input  logic        rst_n,
   input  logic        init,
   input  logic        read_req,
   input  logic [31:0] read_addr,
   input  logic        SD_DATAOUT,
   output logic        SD_CS,
   output logic        SD_DATAIN,
   output logic        read_busy,
   output logic [7:0]  rd_data,
   output logic        rd_valid,
   output logic        read_done,
   output logic        read_err,
   output logic [2:0]  err_code
);

   localparam int unsigned CMD_BITS  = 48;
   localparam int unsigned CRC_BITS  = 16;
   localparam int unsigned TAIL_CLKS = 8;
   localparam int unsigned MAX_A     = (BLOCK_BYTES > CMD_BITS) ? BLOCK_BYTES : CMD_BITS;
   localparam int unsigned MAX_B     = (RESP_TIMEOUT > TOKEN_TIMEOUT) ? RESP_TIMEOUT : TOKEN_TIMEOUT;
   localparam int unsigned CNT_MAX   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);

   localparam logic [2:0] ERR_NONE    = 3'd0;
   localparam logic [2:0] ERR_R1_TO   = 3'd1;
   localparam logic [2:0] ERR_R1_BAD  = 3'd2;
   localparam logic [2:0] ERR_TOK_TO  = 3'd3;
   localparam logic [2:0] ERR_TOK_BAD = 3'd4;
   localparam logic [2:0] ERR_CRC     = 3'd5;

   typedef enum logic [2:0] {
      S_IDLE, S_CMD, S_RESP, S_R1, S_TOKEN, S_DATA, S_CRC, S_TAIL
   } state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [2:0]       r_bit_cnt;
   logic [6:0]       r_byte;
   logic [47:0]      r_cmd_shift;
   logic [2:0]       r_err_pend;
   logic             r_sd_cs;
   logic             r_sd_datain;
   logic             r_read_busy;
   logic [7:0]       r_rd_data;
   logic             r_rd_valid;
   logic             r_read_done;
   logic             r_read_err;
   logic [2:0]       r_err_code;

   logic [31:0]      w_arg;
   logic [47:0]      w_cmd;
   logic [7:0]       w_byte;
   logic             w_byte_end;
   logic             w_crc_bad;

   assign w_arg      = read_addr << ADDR_SHIFT;
   assign w_cmd      = {8'h51, w_arg, 8'hFF};
   assign w_byte     = {r_byte, SD_DATAOUT};
   assign w_byte_end = (r_bit_cnt == 3'd7);

`ifdef SD_CRC16_CHK_EN
   logic [15:0] r_crc;
   logic [14:0] r_crc_rx;
   logic [15:0] w_crc_next;

   assign w_crc_next = {r_crc[14:0], 1'b0} ^ ((r_crc[15] ^ SD_DATAOUT) ? 16'h1021 : 16'h0000);
   assign w_crc_bad  = ({r_crc_rx, SD_DATAOUT} != r_crc);

   // Running CRC over payload bits, cleared while hunting for the start token
   always_ff @(posedge SD_CLK or negedge rst_n) begin
      if (!rst_n) begin
         r_crc    <= '0;
         r_crc_rx <= '0;
      end else begin
         if (r_state == S_TOKEN) r_crc <= '0;
         else if (r_state == S_DATA) r_crc <= w_crc_next;
         if (r_state == S_CRC) r_crc_rx <= {r_crc_rx[13:0], SD_DATAOUT};
      end
   end
`else
   assign w_crc_bad = 1'b0;
`endif

   always_ff @(posedge SD_CLK or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_bit_cnt   <= '0;
         r_byte      <= '0;
         r_cmd_shift <= '1;
         r_err_pend  <= ERR_NONE;
         r_sd_cs     <= 1'b1;
         r_sd_datain <= 1'b1;
         r_read_busy <= 1'b0;
         r_rd_data   <= '0;
         r_rd_valid  <= 1'b0;
         r_read_done <= 1'b0;
         r_read_err  <= 1'b0;
         r_err_code  <= ERR_NONE;
      end else begin
         r_rd_valid  <= 1'b0;
         r_read_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_sd_cs     <= 1'b1;
               r_sd_datain <= 1'b1;
               r_read_busy <= 1'b0;
               if (init && read_req) begin
                  r_read_busy <= 1'b1;
                  r_read_err  <= 1'b0;
                  r_err_code  <= ERR_NONE;
                  r_err_pend  <= ERR_NONE;
                  r_sd_cs     <= 1'b0;
                  r_sd_datain <= w_cmd[47];
                  r_cmd_shift <= {w_cmd[46:0], 1'b1};
                  r_cnt       <= CNT_W'(CMD_BITS - 1);
                  r_state     <= S_CMD;
               end
            end
            S_CMD: begin
               if (r_cnt == '0) begin
                  r_sd_datain <= 1'b1;
                  r_cnt       <= CNT_W'(RESP_TIMEOUT);
                  r_state     <= S_RESP;
               end else begin
                  r_sd_datain <= r_cmd_shift[47];
                  r_cmd_shift <= {r_cmd_shift[46:0], 1'b1};
                  r_cnt       <= r_cnt - CNT_W'(1);
               end
            end
            // First low bit on MISO is R1[7]; seven more bits follow
            S_RESP: begin
               if (!SD_DATAOUT) begin
                  r_byte    <= '0;
                  r_bit_cnt <= 3'd1;
                  r_state   <= S_R1;
               end else if (r_cnt <= CNT_W'(1)) begin
                  r_err_pend <= ERR_R1_TO;
                  r_cnt      <= CNT_W'(TAIL_CLKS - 1);
                  r_state    <= S_TAIL;
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            S_R1: begin
               r_byte    <= w_byte[6:0];
               r_bit_cnt <= r_bit_cnt + 3'd1;
               if (w_byte_end) begin
                  if (w_byte == 8'h00) begin
                     r_cnt   <= CNT_W'(TOKEN_TIMEOUT);
                     r_state <= S_TOKEN;
                  end else begin
                     r_err_pend <= ERR_R1_BAD;
                     r_cnt      <= CNT_W'(TAIL_CLKS - 1);
                     r_state    <= S_TAIL;
                  end
               end
            end
            // Anything other than the start token or a data-error token counts as idle fill
            S_TOKEN: begin
               r_byte    <= w_byte[6:0];
               r_bit_cnt <= r_bit_cnt + 3'd1;
               if (w_byte_end) begin
                  if (w_byte == 8'hFE) begin
                     r_cnt   <= CNT_W'(BLOCK_BYTES - 1);
                     r_state <= S_DATA;
                  end else if (w_byte[7:4] == 4'h0) begin
                     r_err_pend <= ERR_TOK_BAD;
                     r_cnt      <= CNT_W'(TAIL_CLKS - 1);
                     r_state    <= S_TAIL;
                  end else if (r_cnt <= CNT_W'(1)) begin
                     r_err_pend <= ERR_TOK_TO;
                     r_cnt      <= CNT_W'(TAIL_CLKS - 1);
                     r_state    <= S_TAIL;
                  end else begin
                     r_cnt <= r_cnt - CNT_W'(1);
                  end
               end
            end
            S_DATA: begin
               r_byte    <= w_byte[6:0];
               r_bit_cnt <= r_bit_cnt + 3'd1;
               if (w_byte_end) begin
                  r_rd_data  <= w_byte;
                  r_rd_valid <= 1'b1;
                  if (r_cnt == '0) begin
                     r_cnt   <= CNT_W'(CRC_BITS - 1);
                     r_state <= S_CRC;
                  end else begin
                     r_cnt <= r_cnt - CNT_W'(1);
                  end
               end
            end
            S_CRC: begin
               if (r_cnt == '0) begin
                  if (w_crc_bad) r_err_pend <= ERR_CRC;
                  r_cnt   <= CNT_W'(TAIL_CLKS - 1);
                  r_state <= S_TAIL;
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            // Every path ends here so the card always gets its trailing clocks
            S_TAIL: begin
               if (r_cnt == '0) begin
                  r_sd_cs     <= 1'b1;
                  r_read_done <= 1'b1;
                  r_read_err  <= (r_err_pend != ERR_NONE);
                  r_err_code  <= r_err_pend;
                  r_state     <= S_IDLE;
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign SD_CS     = r_sd_cs;
   assign SD_DATAIN = r_sd_datain;
   assign read_busy = r_read_busy;
   assign rd_data   = r_rd_data;
   assign rd_valid  = r_rd_valid;
   assign read_done = r_read_done;
   assign read_err  = r_read_err;
   assign err_code  = r_err_code;

endmodule

// File: tb/tb_sd_block_read.sv
// Bench for sd_block_read: SPI card model, directed vector table, mid-transfer reset and random reads.
module tb_sd_block_read;

   localparam int unsigned BB        = 512;
   localparam int unsigned RTO       = 128;
   localparam int unsigned TTO       = 64;
   localparam int unsigned ASH       = 9;
   localparam int          TXN_LIMIT = 8000;
`ifdef SD_CRC16_CHK_EN
   localparam logic [2:0] CRC_ERR = 3'd5;
`else
   localparam logic [2:0] CRC_ERR = 3'd0;
`endif

   typedef struct {
      int unsigned ones;       // idle-high MISO bits before R1
      logic [7:0]  r1;
      int unsigned gap;        // filler bytes before the token
      logic [7:0]  tok;
      bit          rnd_pl;     // random payload/filler instead of i&0xFF / 0xFF
      bit          corrupt;    // flip a CRC bit
      logic [31:0] addr;
      bit          poke;       // extra read_req while busy
      logic [2:0]  exp_err;
      int unsigned exp_nbytes;
      int unsigned exp_cyc;    // busy-rise to read_done cycles, 0 = unchecked
   } vec_t;

   logic        SD_CLK = 1'b0;
   logic        rst_n;
   logic        init;
   logic        read_req;
   logic [31:0] read_addr;
   logic        miso = 1'b1;
   logic        SD_CS;
   logic        SD_DATAIN;
   logic        read_busy;
   logic [7:0]  rd_data;
   logic        rd_valid;
   logic        read_done;
   logic        read_err;
   logic [2:0]  err_code;

   int n_checks = 0;
   int n_errors = 0;

   logic        resp_q[$];
   logic [7:0]  pl_q[$];
   logic [7:0]  rx_q[$];
   int          done_cnt = 0;
   logic [47:0] cmd_bits = '0;
   int          cmd_cnt  = 0;
   int          card_idx = 0;
   vec_t        vecs[8];

   always #5 SD_CLK = ~SD_CLK;

   sd_block_read #(
      .BLOCK_BYTES  (BB),
      .RESP_TIMEOUT (RTO),
      .TOKEN_TIMEOUT(TTO),
      .ADDR_SHIFT   (ASH)
   ) u_dut (
      .SD_CLK    (SD_CLK),
      .rst_n     (rst_n),
      .init      (init),
      .read_req  (read_req),
      .read_addr (read_addr),
      .SD_DATAOUT(miso),
      .SD_CS     (SD_CS),
      .SD_DATAIN (SD_DATAIN),
      .read_busy (read_busy),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid),
      .read_done (read_done),
      .read_err  (read_err),
      .err_code  (err_code)
   );

   // Card: captures the 48 command bits, then plays back resp_q one bit per clock
   always @(negedge SD_CLK) begin
      if (SD_CS) begin
         cmd_cnt  <= 0;
         card_idx <= 0;
         miso     <= 1'b1;
      end else if (cmd_cnt < 48) begin
         cmd_bits[47-cmd_cnt] <= SD_DATAIN;
         cmd_cnt              <= cmd_cnt + 1;
         miso                 <= 1'b1;
      end else begin
         miso     <= (card_idx < resp_q.size()) ? resp_q[card_idx] : 1'b1;
         card_idx <= card_idx + 1;
      end
   end

   always @(negedge SD_CLK) begin
      if (rd_valid === 1'b1) rx_q.push_back(rd_data);
      if (read_done === 1'b1) done_cnt <= done_cnt + 1;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic bound_fail(input string name, input int cyc);
      n_checks++;
      n_errors++;
      $display("FAIL %s: no event after %0d cycles", name, cyc);
   endtask

   task automatic push_byte(input logic [7:0] b);
      for (int k = 7; k >= 0; k--) resp_q.push_back(b[k]);
   endtask

   function automatic logic [7:0] filler(input bit rnd);
      logic [7:0] f;
      f = 8'hFF;
      if (rnd) begin
         f = {4'($urandom_range(1, 15)), 4'($urandom)};
         if (f == 8'hFE) f = 8'hFF;
      end
      return f;
   endfunction

   // Builds the MISO stream and the expected payload for one transaction
   task automatic build(input vec_t v);
      logic [15:0] crc;
      logic [7:0]  b;
      logic        fb;
      resp_q.delete();
      pl_q.delete();
      crc = 16'h0000;
      for (int i = 0; i < int'(v.ones); i++) resp_q.push_back(1'b1);
      push_byte(v.r1);
      for (int i = 0; i < int'(v.gap); i++) push_byte(filler(v.rnd_pl));
      push_byte(v.tok);
      for (int i = 0; i < int'(BB); i++) begin
         b = v.rnd_pl ? 8'($urandom) : 8'(i);
         pl_q.push_back(b);
         push_byte(b);
         for (int k = 7; k >= 0; k--) begin
            fb  = crc[15] ^ b[k];
            crc = {crc[14:0], 1'b0};
            if (fb) crc = crc ^ 16'h1021;
         end
      end
      if (v.corrupt) crc = crc ^ 16'h0100;
      push_byte(crc[15:8]);
      push_byte(crc[7:0]);
   endtask

   // Outcome of a read from the card behaviour alone
   function automatic vec_t model(input vec_t v);
      vec_t r;
      r            = v;
      r.exp_nbytes = 0;
      r.exp_cyc    = 0;
      if (v.ones >= RTO)          r.exp_err = 3'd1;
      else if (v.r1 != 8'h00)     r.exp_err = 3'd2;
      else if (v.gap >= TTO)      r.exp_err = 3'd3;
      else if (v.tok != 8'hFE)    r.exp_err = 3'd4;
      else begin
         r.exp_nbytes = BB;
         r.exp_err    = v.corrupt ? CRC_ERR : 3'd0;
      end
      return r;
   endfunction

   task automatic run_txn(input string tag, input vec_t v);
      int          base;
      int          cyc;
      int          nrx;
      int          bad;
      logic [31:0] arg;
      build(v);
      base = rx_q.size();
      @(negedge SD_CLK);
      read_addr = v.addr;
      read_req  = 1'b1;
      @(negedge SD_CLK);
      read_req = 1'b0;
      chk({tag, " busy_rise"}, 64'(read_busy), 64'd1);
      cyc = 0;
      while (read_done !== 1'b1 && cyc < TXN_LIMIT) begin
         @(negedge SD_CLK);
         cyc++;
         read_req = (v.poke && cyc == 60);
      end
      read_req = 1'b0;
      if (read_done !== 1'b1) begin
         bound_fail({tag, " done_wait"}, cyc);
         return;
      end
      chk({tag, " err_code"}, 64'(err_code), 64'(v.exp_err));
      chk({tag, " read_err"}, 64'(read_err), 64'(v.exp_err != 3'd0));
      chk({tag, " cs_high_at_done"}, 64'(SD_CS), 64'd1);
      nrx = rx_q.size() - base;
      chk({tag, " nbytes"}, 64'(nrx), 64'(v.exp_nbytes));
      if (v.exp_nbytes != 0) begin
         bad = 0;
         for (int i = 0; i < nrx && i < int'(v.exp_nbytes); i++)
            if (rx_q[base+i] !== pl_q[i]) bad++;
         chk({tag, " payload_mismatches"}, 64'(bad), 64'd0);
      end
      arg = v.addr << ASH;
      chk({tag, " cmd17"}, 64'(cmd_bits), 64'({8'h51, arg, 8'hFF}));
      if (v.exp_cyc != 0) chk({tag, " done_latency"}, 64'(cyc), 64'(v.exp_cyc));
      @(negedge SD_CLK);
      chk({tag, " busy_fall"}, 64'(read_busy), 64'd0);
      chk({tag, " done_strobe"}, 64'(read_done), 64'd0);
      if (v.poke) begin
         repeat (5) @(negedge SD_CLK);
         chk({tag, " poke_not_queued"}, 64'({read_busy, SD_CS}), 64'b01);
      end
   endtask

   initial begin
      int base;
      int cyc;
      int d0;
      vec_t rv;

      rst_n     = 1'b0;
      init      = 1'b0;
      read_req  = 1'b0;
      read_addr = '0;

      //          ones     r1     gap      tok    rnd  cor  addr            poke err   nbytes cyc
      vecs[0] = '{24,      8'h00, 10,      8'hFE, 1'b0, 1'b0, 32'd3,         1'b0, 3'd0, 512, 0};
      vecs[1] = '{200,     8'h00, 0,       8'hFE, 1'b0, 1'b0, 32'd7,         1'b0, 3'd1, 0,   48 + 128 + 8};
      vecs[2] = '{5,       8'h04, 0,       8'hFE, 1'b0, 1'b0, 32'd1,         1'b0, 3'd2, 0,   0};
      vecs[3] = '{8,       8'h00, 0,       8'h08, 1'b0, 1'b0, 32'd2,         1'b0, 3'd4, 0,   0};
      vecs[4] = '{3,       8'h00, TTO + 4, 8'hFE, 1'b0, 1'b0, 32'd9,         1'b1, 3'd3, 0,   0};
      vecs[5] = '{16,      8'h00, 2,       8'hFE, 1'b1, 1'b1, 32'h0012_3456, 1'b0, CRC_ERR, 512, 0};
      vecs[6] = '{RTO - 1, 8'h00, TTO - 1, 8'hFE, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0, 3'd0, 512, 0};
      vecs[7] = '{0,       8'h00, TTO,     8'hFE, 1'b0, 1'b0, 32'd5,         1'b0, 3'd3, 0,   0};

      repeat (3) @(negedge SD_CLK);
      chk("rst SD_CS", 64'(SD_CS), 64'd1);
      chk("rst SD_DATAIN", 64'(SD_DATAIN), 64'd1);
      chk("rst read_busy", 64'(read_busy), 64'd0);
      chk("rst rd_data", 64'(rd_data), 64'd0);
      chk("rst rd_valid", 64'(rd_valid), 64'd0);
      chk("rst read_done", 64'(read_done), 64'd0);
      chk("rst read_err", 64'(read_err), 64'd0);
      chk("rst err_code", 64'(err_code), 64'd0);
      rst_n = 1'b1;

      // Requests before init are dropped
      @(negedge SD_CLK);
      read_req = 1'b1;
      repeat (3) @(negedge SD_CLK);
      read_req = 1'b0;
      chk("no_init busy", 64'(read_busy), 64'd0);
      chk("no_init cs", 64'(SD_CS), 64'd1);
      init = 1'b1;

      for (int i = 0; i < 8; i++) run_txn($sformatf("vec%0d", i), vecs[i]);

      // Reset while byte 100 of the payload is being streamed
      build(vecs[0]);
      base = rx_q.size();
      d0   = done_cnt;
      @(negedge SD_CLK);
      read_addr = 32'd3;
      read_req  = 1'b1;
      @(negedge SD_CLK);
      read_req = 1'b0;
      cyc = 0;
      while ((rx_q.size() - base) < 100 && cyc < TXN_LIMIT) begin
         @(negedge SD_CLK);
         cyc++;
      end
      if ((rx_q.size() - base) < 100) bound_fail("midrst byte100_wait", cyc);
      rst_n = 1'b0;
      #1;
      chk("midrst SD_CS", 64'(SD_CS), 64'd1);
      chk("midrst read_busy", 64'(read_busy), 64'd0);
      repeat (3) @(negedge SD_CLK);
      rst_n = 1'b1;
      repeat (2) @(negedge SD_CLK);
      chk("midrst no_done", 64'(done_cnt - d0), 64'd0);
      run_txn("post_rst", vecs[0]);

      for (int i = 0; i < 6; i++) begin
         rv.ones    = ($urandom_range(0, 5) == 0) ? $urandom_range(RTO, RTO + 8) : $urandom_range(0, RTO - 1);
         rv.r1      = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(1, 127)) : 8'h00;
         rv.gap     = ($urandom_range(0, 5) == 0) ? $urandom_range(TTO, TTO + 3) : $urandom_range(0, TTO - 1);
         rv.tok     = ($urandom_range(0, 5) == 0) ? {4'h0, 4'($urandom)} : 8'hFE;
         rv.rnd_pl  = 1'b1;
         rv.corrupt = ($urandom_range(0, 3) == 0);
         rv.addr    = $urandom;
         rv.poke    = 1'b0;
         rv.exp_err = 3'd0;
         rv.exp_nbytes = 0;
         rv.exp_cyc = 0;
         run_txn($sformatf("rnd%0d", i), model(rv));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
